// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core.
//  sw_state_t : control FSM states (IDLE, RUN, STOP, LAP)
//  bcd_t      : one 4-bit BCD digit
//  DIGITS     : number of BCD digits on the display bus (MM:SS.cc)
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2,
        LAP  = 2'd3
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam int DIGITS = 6;

endpackage

// File: rtl/stopwatch_core_bcd_digit.sv
// Single BCD digit counter with wrap at MAX.
//  clk_i   : system clock
//  rst_ni  : synchronous active-low reset
//  clr_i   : synchronous clear to zero (wins over inc_i)
//  inc_i   : advance the digit by one this cycle
//  q_o     : current digit value, 0..MAX
//  carry_o : combinational carry into the next digit (inc_i while at MAX)
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX = 9
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output bcd_t q_o,
    output logic carry_o
);

    localparam bcd_t MAX_Q = bcd_t'(MAX);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_o <= '0;
        end else if (clr_i) begin
            q_o <= '0;
        end else if (inc_i) begin
            q_o <= (q_o == MAX_Q) ? '0 : q_o + 4'd1;
        end
    end

    // Carry is combinational so a whole chain of digits rolls over on one edge.
    assign carry_o = inc_i && (q_o == MAX_Q);

endmodule

// File: rtl/stopwatch_core.sv
// BCD MM:SS.cc stopwatch driven by a 1/100 s enable pulse.
//  clk_i        : system clock
//  rst_ni       : synchronous active-low reset
//  tick_i       : one-cycle enable pulse from the upstream tick counter
//  start_stop_i : one-cycle pulse, toggle run/stop
//  lap_i        : one-cycle pulse, freeze/unfreeze the display while running
//  clear_i      : one-cycle pulse, return to zero and idle
//  disp_o       : {min_t,min_u,sec_t,sec_u,cs_t,cs_u}, 4-bit BCD each
//  running_o    : high in RUN or LAP
//  lap_o        : high in LAP (display frozen on lap register)
//  overflow_o   : sticky flag, set on MAX_MIN:59.99 -> 00:00.00 wrap
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICKS_PER_CS = 1,
    parameter int unsigned MAX_MIN      = 59
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                tick_i,
    input  logic                start_stop_i,
    input  logic                lap_i,
    input  logic                clear_i,
    output logic [DIGITS*4-1:0] disp_o,
    output logic                running_o,
    output logic                lap_o,
    output logic                overflow_o
);

    localparam bcd_t MIN_T_MAX = bcd_t'(MAX_MIN / 10);
    localparam bcd_t MIN_U_MAX = bcd_t'(MAX_MIN % 10);

    sw_state_t state, state_next;

    logic active;
    logic presc_done;
    logic step;

    bcd_t cs_u, cs_t, sec_u, sec_t, min_u, min_t;
    logic c_cs_u, c_cs_t, c_sec_u, c_sec_t;
    logic min_at_max;
    logic wrap;

    logic [DIGITS*4-1:0] count;
    logic [DIGITS*4-1:0] lap_reg;

    assign active = (state == RUN) || (state == LAP);

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; clear beats start/stop, which beats lap.
    always_comb begin
        state_next = state;
        if (clear_i) begin
            state_next = IDLE;
        end else if (start_stop_i) begin
            case (state)
                IDLE:    state_next = RUN;
                RUN:     state_next = STOP;
                LAP:     state_next = STOP;
                STOP:    state_next = RUN;
                default: state_next = IDLE;
            endcase
        end else if (lap_i) begin
            case (state)
                RUN:     state_next = LAP;
                LAP:     state_next = RUN;
                default: state_next = state;
            endcase
        end
    end

    // Prescaler only exists when several ticks make one centisecond. It
    // advances on ticks seen while counting, holds in STOP and restarts
    // from zero in IDLE or on clear.
    generate
        if (TICKS_PER_CS > 1) begin : g_presc
            localparam int PW = $clog2(TICKS_PER_CS);
            localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_CS - 1);

            logic [PW-1:0] presc;

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    presc <= '0;
                end else if (clear_i || (state == IDLE)) begin
                    presc <= '0;
                end else if (active && tick_i) begin
                    presc <= (presc == PMAX) ? '0 : presc + 1'b1;
                end
            end

            assign presc_done = (presc == PMAX);
        end else begin : g_no_presc
            assign presc_done = 1'b1;
        end
    endgenerate

    // Step decision uses the current state, so a tick arriving with the
    // start pulse is ignored and a tick arriving with the stop pulse counts.
    assign step = active && tick_i && presc_done && !clear_i;

    bcd_digit #(.MAX(9)) u_cs_u (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clear_i),
        .inc_i(step), .q_o(cs_u), .carry_o(c_cs_u)
    );

    bcd_digit #(.MAX(9)) u_cs_t (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clear_i),
        .inc_i(c_cs_u), .q_o(cs_t), .carry_o(c_cs_t)
    );

    bcd_digit #(.MAX(9)) u_sec_u (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clear_i),
        .inc_i(c_cs_t), .q_o(sec_u), .carry_o(c_sec_u)
    );

    bcd_digit #(.MAX(5)) u_sec_t (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clear_i),
        .inc_i(c_sec_u), .q_o(sec_t), .carry_o(c_sec_t)
    );

    // Minutes wrap on the two-digit value MAX_MIN rather than at 99, so the
    // pair is handled together instead of as two independent digits.
    assign min_at_max = (min_t == MIN_T_MAX) && (min_u == MIN_U_MAX);
    assign wrap       = c_sec_t && min_at_max;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            min_u <= '0;
            min_t <= '0;
        end else if (c_sec_t) begin
            if (min_at_max) begin
                min_u <= '0;
                min_t <= '0;
            end else if (min_u == 4'd9) begin
                min_u <= '0;
                min_t <= min_t + 4'd1;
            end else begin
                min_u <= min_u + 4'd1;
            end
        end
    end

    // Sticky wrap flag, only cleared by reset or clear.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            overflow_o <= 1'b0;
        end else if (wrap) begin
            overflow_o <= 1'b1;
        end
    end

    assign count = {min_t, min_u, sec_t, sec_u, cs_t, cs_u};

    // Lap capture takes the value shown this cycle, before any same-cycle step.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            lap_reg <= '0;
        end else if ((state == RUN) && lap_i && !start_stop_i) begin
            lap_reg <= count;
        end
    end

    assign running_o = active;
    assign lap_o     = (state == LAP);
    assign disp_o    = lap_o ? lap_reg : count;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core. Three instances share one stimulus:
// default parameters, MAX_MIN=1 (short route to the minute wrap) and
// TICKS_PER_CS=4 (prescaler behaviour).
module tb_stopwatch_core;

    logic clk;
    logic rstN;
    logic tick;
    logic startStop;
    logic lapPulse;
    logic clearPulse;

    logic [23:0] dispMain, dispWrap, dispPresc;
    logic runMain, runWrap, runPresc;
    logic lapMain, lapWrap, lapPresc;
    logic ovfMain, ovfWrap, ovfPresc;

    int vectorCount = 0;
    int missCount   = 0;

    stopwatch_core dutMain (
        .clk_i(clk), .rst_ni(rstN), .tick_i(tick), .start_stop_i(startStop),
        .lap_i(lapPulse), .clear_i(clearPulse), .disp_o(dispMain),
        .running_o(runMain), .lap_o(lapMain), .overflow_o(ovfMain)
    );

    stopwatch_core #(.TICKS_PER_CS(1), .MAX_MIN(1)) dutWrap (
        .clk_i(clk), .rst_ni(rstN), .tick_i(tick), .start_stop_i(startStop),
        .lap_i(lapPulse), .clear_i(clearPulse), .disp_o(dispWrap),
        .running_o(runWrap), .lap_o(lapWrap), .overflow_o(ovfWrap)
    );

    stopwatch_core #(.TICKS_PER_CS(4), .MAX_MIN(59)) dutPresc (
        .clk_i(clk), .rst_ni(rstN), .tick_i(tick), .start_stop_i(startStop),
        .lap_i(lapPulse), .clear_i(clearPulse), .disp_o(dispPresc),
        .running_o(runPresc), .lap_o(lapPresc), .overflow_o(ovfPresc)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expectation and tally the result.
    task automatic checkOutput(input string tag, input logic [23:0] got, input logic [23:0] exp);
        vectorCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the edge.
    task automatic applyStimulus(input logic ss, input logic lp, input logic clr, input logic tk);
        startStop  = ss;
        lapPulse   = lp;
        clearPulse = clr;
        tick       = tk;
        @(posedge clk);
        #1;
        startStop  = 1'b0;
        lapPulse   = 1'b0;
        clearPulse = 1'b0;
        tick       = 1'b0;
    endtask

    task automatic runTicks(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rstN       = 1'b0;
        tick       = 1'b0;
        startStop  = 1'b0;
        lapPulse   = 1'b0;
        clearPulse = 1'b0;

        // Reset held with tick toggling.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, i[0]);
        checkOutput("reset disp", dispMain, 24'h000000);
        checkOutput("reset running", 24'(runMain), 24'd0);
        checkOutput("reset lap", 24'(lapMain), 24'd0);
        checkOutput("reset overflow", 24'(ovfMain), 24'd0);
        rstN = 1'b1;

        // Basic counting.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("start running", 24'(runMain), 24'd1);
        runTicks(100);
        checkOutput("100 ticks", dispMain, 24'h000100);
        runTicks(5900);
        checkOutput("6000 ticks", dispMain, 24'h010000);
        checkOutput("6000 ticks presc4", dispPresc, 24'h001500);

        // Lap freeze and release; lap pulse carries a tick that still counts.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("clear disp", dispMain, 24'h000000);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runTicks(1234);
        checkOutput("run to 12.34", dispMain, 24'h001234);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("lap frozen", dispMain, 24'h001234);
        checkOutput("lap flag", 24'(lapMain), 24'd1);
        runTicks(49);
        checkOutput("lap held", dispMain, 24'h001234);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("lap release", dispMain, 24'h001284);
        checkOutput("lap flag off", 24'(lapMain), 24'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runTicks(20);
        checkOutput("stopped hold", dispMain, 24'h001284);
        checkOutput("stopped running", 24'(runMain), 24'd0);

        // Minute wrap: MAX_MIN=1 instance wraps at 01:59.99, default does not.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runTicks(11999);
        checkOutput("wrap pre", dispWrap, 24'h015999);
        checkOutput("wrap pre ovf", 24'(ovfWrap), 24'd0);
        runTicks(1);
        checkOutput("wrap disp", dispWrap, 24'h000000);
        checkOutput("wrap ovf", 24'(ovfWrap), 24'd1);
        checkOutput("main 2 min", dispMain, 24'h020000);
        checkOutput("main no ovf", 24'(ovfMain), 24'd0);
        runTicks(1);
        checkOutput("wrap continues", dispWrap, 24'h000001);
        checkOutput("ovf sticky", 24'(ovfWrap), 24'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("clear ovf", 24'(ovfWrap), 24'd0);
        checkOutput("clear idle", 24'(runWrap), 24'd0);
        checkOutput("clear wrap disp", dispWrap, 24'h000000);

        // Simultaneous inputs.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("idle lap ignored", 24'(lapMain), 24'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("idle tick+start", dispMain, 24'h000000);
        checkOutput("idle tick+start run", 24'(runMain), 24'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("run tick+stop", dispMain, 24'h000001);
        checkOutput("run tick+stop state", 24'(runMain), 24'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("clear+start+tick", dispMain, 24'h000000);
        checkOutput("clear+start+tick run", 24'(runMain), 24'd0);

        // Prescaler of 4.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runTicks(8);
        checkOutput("presc 8 ticks", dispPresc, 24'h000002);
        runTicks(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("presc stopped", dispPresc, 24'h000002);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runTicks(1);
        checkOutput("presc resume 1", dispPresc, 24'h000002);
        runTicks(1);
        checkOutput("presc resume 2", dispPresc, 24'h000003);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
